// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with start/busy/done handshake,
// optional signed mode, leading-one aligned iteration count, div-by-zero and MIN/-1 handling.
module seq_divider #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, NORM, ITER, FIXUP, DONE} state_t;
  typedef enum logic [1:0] {PATH_NORMAL, PATH_DBZ, PATH_OVF} path_t;

  state_t           r_state;
  state_t           w_state_nxt;
  path_t            r_path;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_signed;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_sdiv;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;

  logic             w_neg_dvd;
  logic             w_neg_dvs;
  logic [WIDTH-1:0] w_mag_dvd;
  logic [WIDTH-1:0] w_mag_dvs;
  logic [CW-1:0]    w_pd;
  logic [CW-1:0]    w_ps;
  logic [CW-1:0]    w_shamt;
  logic             w_dvs_zero;
  logic             w_ovf_case;
  logic             w_small;
  logic             w_ge;

  function automatic logic [CW-1:0] f_lead_one(input logic [WIDTH-1:0] v);
    logic [CW-1:0] pos;
    pos = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) pos = CW'(i);
    end
    return pos;
  endfunction

  // Magnitudes of MIN stay representable as unsigned WIDTH-bit values.
  always_comb begin
    w_neg_dvd  = r_signed & r_dvd[WIDTH-1];
    w_neg_dvs  = r_signed & r_dvs[WIDTH-1];
    w_mag_dvd  = w_neg_dvd ? -r_dvd : r_dvd;
    w_mag_dvs  = w_neg_dvs ? -r_dvs : r_dvs;
    w_pd       = f_lead_one(w_mag_dvd);
    w_ps       = f_lead_one(w_mag_dvs);
    w_shamt    = w_pd - w_ps;
    w_dvs_zero = (r_dvs == '0);
    w_ovf_case = r_signed && (r_dvd == MIN_VAL) && (r_dvs == '1);
    w_small    = (w_mag_dvd < w_mag_dvs);
    w_ge       = (r_rem >= r_sdiv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = NORM;
      end
      NORM: begin
        busy = 1'b1;
        if (w_dvs_zero || w_ovf_case || w_small) w_state_nxt = FIXUP;
        else                                     w_state_nxt = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (r_cnt == CW'(1)) w_state_nxt = FIXUP;
      end
      FIXUP: begin
        busy        = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_signed <= 1'b0;
      r_rem    <= '0;
      r_sdiv   <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_path   <= PATH_NORMAL;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd    <= dividend;
            r_dvs    <= divisor;
            r_signed <= is_signed & SIGNED_EN;
          end
        end
        NORM: begin
          r_sign_q <= w_neg_dvd ^ w_neg_dvs;
          r_sign_r <= w_neg_dvd;
          r_q      <= '0;
          r_rem    <= w_mag_dvd;
          r_sdiv   <= w_mag_dvs << w_shamt;
          r_cnt    <= w_shamt + CW'(1);
          if (w_dvs_zero)      r_path <= PATH_DBZ;
          else if (w_ovf_case) r_path <= PATH_OVF;
          else                 r_path <= PATH_NORMAL;
        end
        ITER: begin
          if (w_ge) r_rem <= r_rem - r_sdiv;
          r_q    <= {r_q[WIDTH-2:0], w_ge};
          r_sdiv <= r_sdiv >> 1;
          r_cnt  <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers only move on the FIXUP edge, so they hold while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (r_state == FIXUP) begin
      unique case (r_path)
        PATH_DBZ: begin
          quotient    <= '1;
          remainder   <= r_dvd;
          div_by_zero <= 1'b1;
          overflow    <= 1'b0;
        end
        PATH_OVF: begin
          quotient    <= r_dvd;
          remainder   <= '0;
          div_by_zero <= 1'b0;
          overflow    <= 1'b1;
        end
        default: begin
          quotient    <= r_sign_q ? -r_q : r_q;
          remainder   <= r_sign_r ? -r_rem : r_rem;
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised bench for seq_divider: arithmetic reference model plus per-cycle compare,
// with directed operand cases pinned to hand-computed results.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // expected visible outputs and the pending transaction
  logic [31:0] cur_q = '0, cur_r = '0;
  logic        cur_dz = 1'b0, cur_ov = 1'b0;
  logic [31:0] p_q, p_r;
  logic        p_dz, p_ov;
  int          p_acc, p_done;
  bit          pending = 1'b0;

  // actual values captured whenever the DUT pulses done
  logic [31:0] cap_q, cap_r;
  logic        cap_dz, cap_ov;
  int          last_done_cyc = -1;
  int          n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int msb64(input longint v);
    int m = 0;
    for (int i = 0; i < 64; i++) if (v[i]) m = i;
    return m;
  endfunction

  // Reference: plain integer division on sign/zero-extended 64-bit values.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input bit s,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output logic ov, output int lat);
    longint sa, sb, ma, mb, lq, lr;
    int k;
    dz = 1'b0; ov = 1'b0;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 3;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'h0; ov = 1'b1; lat = 3;
    end else begin
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      k  = (ma < mb) ? 0 : msb64(ma) - msb64(mb) + 1;
      lat = k + 3;
    end
  endtask

  // Per-cycle compare against the model's view of what must be visible now.
  always @(negedge clk) begin
    bit exp_done, exp_busy;
    if (done === 1'b1) begin
      cap_q = quotient; cap_r = remainder; cap_dz = div_by_zero; cap_ov = overflow;
      last_done_cyc = cyc;
      n_done++;
    end
    if (!rst_n) begin
      pending = 1'b0;
      cur_q = '0; cur_r = '0; cur_dz = 1'b0; cur_ov = 1'b0;
      exp_done = 1'b0; exp_busy = 1'b0;
    end else begin
      exp_done = pending && (cyc == p_done);
      exp_busy = pending && (cyc >= p_acc) && (cyc < p_done);
      if (exp_done) begin
        cur_q = p_q; cur_r = p_r; cur_dz = p_dz; cur_ov = p_ov;
        pending = 1'b0;
      end
    end
    chk("done", 32'(done), 32'(exp_done));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("quotient", quotient, cur_q);
    chk("remainder", remainder, cur_r);
    chk("div_by_zero", 32'(div_by_zero), 32'(cur_dz));
    chk("overflow", 32'(overflow), 32'(cur_ov));
  end

  // Called at a negedge with the DUT idle; returns at an idle negedge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit s);
    int lat;
    model(a, b, s, p_q, p_r, p_dz, p_ov, lat);
    p_acc  = cyc + 1;
    p_done = p_acc + lat - 1;
    last_done_cyc = -1;
    n_done = 0;
    pending = 1'b1;
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit s, input bit noise);
    int dc, guard;
    launch(a, b, s);
    dc = p_done;
    guard = 0;
    while (cyc < dc && guard < 100) begin
      @(negedge clk);
      guard++;
      if (noise && cyc <= dc) begin
        start     = ($urandom % 3 == 0);
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = $urandom % 2;
      end else begin
        start = 1'b0;
      end
    end
    repeat (1 + $urandom % 2) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input bit s, input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input logic eov, input int elat);
    int acc;
    do_op(a, b, s, 1'b1);
    acc = p_acc;
    chk({nm, ".q"}, cap_q, eq);
    chk({nm, ".r"}, cap_r, er);
    chk({nm, ".dbz"}, 32'(cap_dz), 32'(edz));
    chk({nm, ".ovf"}, 32'(cap_ov), 32'(eov));
    chk({nm, ".latency"}, 32'(last_done_cyc - acc + 1), 32'(elat));
    chk({nm, ".done_count"}, 32'(n_done), 32'd1);
  endtask

  initial begin
    logic [31:0] a, b;
    bit s;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.q", quotient, 32'd0);
    chk("reset.r", remainder, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    directed("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 1'b0, 8);
    directed("s-100_7",  32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 1'b0, 8);
    directed("s100_-7",  32'd100,        32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2,  32'd2,          1'b0, 1'b0, 8);
    directed("dbz",      32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234,  1'b1, 1'b0, 3);
    directed("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 1'b1, 3);
    directed("u_min_m1", 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0, 1'b0, 3);
    directed("u_max_1",  32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 35);

    for (int i = 0; i < 120; i++) begin
      a = $urandom; b = $urandom; s = $urandom % 2;
      case ($urandom % 6)
        0: ;
        1: b = $urandom % 16;
        2: b = 32'd0;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: b = a >> ($urandom % 8);
        default: a = $urandom % 64;
      endcase
      do_op(a, b, s, ($urandom % 2) == 1);
    end

    // asynchronous reset during the third ITER cycle
    launch(32'hFFFF_FFFF, 32'd1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    pending = 1'b0;
    #1;
    chk("midreset.busy", 32'(busy), 32'd0);
    chk("midreset.done", 32'(done), 32'd0);
    chk("midreset.q", quotient, 32'd0);
    chk("midreset.r", remainder, 32'd0);
    n_done = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midreset.no_done", 32'(n_done), 32'd0);
    directed("u9_3",     32'd9,          32'd3,          1'b0, 32'd3,          32'd0,          1'b0, 1'b0, 6);

    for (int i = 0; i < 30; i++) begin
      do_op($urandom, $urandom % 1000, $urandom % 2, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
